// File: rtl/operand_pair_sequencer.sv
// Operand pair sequencer: captures one matched block (index lists + compressed
// value vectors) and streams its (activation, weight) pairs one per cycle.
module operand_pair_sequencer #(
    parameter int BITMASK_LENGTH = 8,
    parameter int INDEX_BITWIDTH = 3,
    parameter int COUNT_BITWIDTH = 4,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 ivalid,
    output logic                                 oready,
    input  logic [63:0]                          matchResult,
    input  logic [BITMASK_LENGTH*DATA_WIDTH-1:0] activationValues,
    input  logic [BITMASK_LENGTH*DATA_WIDTH-1:0] weightValues,
    output logic                                 ovalid,
    input  logic                                 iready,
    output logic [DATA_WIDTH-1:0]                activationOut,
    output logic [DATA_WIDTH-1:0]                weightOut,
    output logic                                 lastPair,
    output logic                                 emptyBlock
);

    localparam int FIELD_W   = BITMASK_LENGTH * INDEX_BITWIDTH;
    localparam int VEC_W     = BITMASK_LENGTH * DATA_WIDTH;
    localparam int PIDX_W    = $clog2(BITMASK_LENGTH);
    localparam int COUNT_LSB = 2 * FIELD_W;
    localparam int SPARE_LSB = COUNT_LSB + COUNT_BITWIDTH;

    localparam logic [COUNT_BITWIDTH-1:0] MAX_COUNT  = COUNT_BITWIDTH'(BITMASK_LENGTH);
    localparam logic [COUNT_BITWIDTH-1:0] COUNT_ONE  = COUNT_BITWIDTH'(1);
    localparam logic [COUNT_BITWIDTH-1:0] COUNT_ZERO = COUNT_BITWIDTH'(0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Index k of a packed index list; only the low bits of k address a lane.
    function automatic logic [INDEX_BITWIDTH-1:0] index_at(
        input logic [FIELD_W-1:0]        field,
        input logic [COUNT_BITWIDTH-1:0] k
    );
        logic [PIDX_W-1:0] slot;
        slot = k[PIDX_W-1:0];
        return field[slot*INDEX_BITWIDTH +: INDEX_BITWIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] value_at(
        input logic [VEC_W-1:0]          vec,
        input logic [INDEX_BITWIDTH-1:0] idx
    );
        return vec[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [COUNT_BITWIDTH-1:0] clamp_count(
        input logic [COUNT_BITWIDTH-1:0] c
    );
        if (c > MAX_COUNT) begin
            return MAX_COUNT;
        end else begin
            return c;
        end
    endfunction

    state_t                    state_r, state_n_s;
    logic [COUNT_BITWIDTH-1:0] pair_idx_r, pair_idx_n_s;
    logic [COUNT_BITWIDTH-1:0] count_r;
    logic [FIELD_W-1:0]        act_idx_r, wt_idx_r;
    logic [VEC_W-1:0]          act_vals_r, wt_vals_r;

    logic                      ovalid_r, ovalid_n_s;
    logic [DATA_WIDTH-1:0]     act_out_r, act_out_n_s;
    logic [DATA_WIDTH-1:0]     wt_out_r, wt_out_n_s;
    logic                      last_r, last_n_s;
    logic                      empty_r, empty_n_s;

    logic                      oready_s;
    logic                      accept_s;
    logic                      handshake_s;
    logic [FIELD_W-1:0]        in_act_idx_s, in_wt_idx_s;
    logic [COUNT_BITWIDTH-1:0] in_count_s;
    logic [DATA_WIDTH-1:0]     first_act_s, first_wt_s;
    logic [COUNT_BITWIDTH-1:0] next_idx_s;
    logic [DATA_WIDTH-1:0]     next_act_s, next_wt_s;
    logic                      next_last_s;
    logic [63-SPARE_LSB:0]     unused_spare_s;

    assign in_act_idx_s   = matchResult[FIELD_W-1:0];
    assign in_wt_idx_s    = matchResult[COUNT_LSB-1:FIELD_W];
    assign in_count_s     = clamp_count(matchResult[SPARE_LSB-1:COUNT_LSB]);
    assign unused_spare_s = matchResult[63:SPARE_LSB];

    // First pair of an incoming block is looked up straight from the inputs so
    // it can be presented the cycle after acceptance.
    assign first_act_s = value_at(activationValues, index_at(in_act_idx_s, COUNT_ZERO));
    assign first_wt_s  = value_at(weightValues, index_at(in_wt_idx_s, COUNT_ZERO));

    assign next_idx_s  = pair_idx_r + COUNT_ONE;
    assign next_act_s  = value_at(act_vals_r, index_at(act_idx_r, next_idx_s));
    assign next_wt_s   = value_at(wt_vals_r, index_at(wt_idx_r, next_idx_s));
    assign next_last_s = (next_idx_s == (count_r - COUNT_ONE));

    assign handshake_s = ovalid_r && iready;
    assign accept_s    = ivalid && oready_s;

    // Ready when idle, or when the final pair of the current block is leaving.
    always_comb begin
        oready_s = 1'b0;
        if (reset) begin
            oready_s = 1'b0;
        end else if (state_r == IDLE) begin
            oready_s = 1'b1;
        end else if (handshake_s && last_r) begin
            oready_s = 1'b1;
        end else begin
            oready_s = 1'b0;
        end
    end

    // Next-state and next-output selection.
    always_comb begin
        state_n_s    = state_r;
        pair_idx_n_s = pair_idx_r;
        ovalid_n_s   = ovalid_r;
        act_out_n_s  = act_out_r;
        wt_out_n_s   = wt_out_r;
        last_n_s     = last_r;
        empty_n_s    = 1'b0;

        if (accept_s) begin
            // Acceptance only happens from IDLE or on the last handshake.
            if (in_count_s == COUNT_ZERO) begin
                state_n_s  = IDLE;
                ovalid_n_s = 1'b0;
                empty_n_s  = 1'b1;
            end else begin
                state_n_s    = EMIT;
                pair_idx_n_s = COUNT_ZERO;
                ovalid_n_s   = 1'b1;
                act_out_n_s  = first_act_s;
                wt_out_n_s   = first_wt_s;
                last_n_s     = (in_count_s == COUNT_ONE);
            end
        end else begin
            case (state_r)
                IDLE: begin
                    ovalid_n_s = 1'b0;
                end
                EMIT: begin
                    if (handshake_s && last_r) begin
                        state_n_s  = IDLE;
                        ovalid_n_s = 1'b0;
                    end else if (handshake_s) begin
                        pair_idx_n_s = next_idx_s;
                        act_out_n_s  = next_act_s;
                        wt_out_n_s   = next_wt_s;
                        last_n_s     = next_last_s;
                    end else begin
                        ovalid_n_s = ovalid_r;
                    end
                end
                default: begin
                    state_n_s  = IDLE;
                    ovalid_n_s = 1'b0;
                end
            endcase
        end
    end

    // Control state and registered output pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            pair_idx_r <= COUNT_ZERO;
            ovalid_r   <= 1'b0;
            act_out_r  <= {DATA_WIDTH{1'b0}};
            wt_out_r   <= {DATA_WIDTH{1'b0}};
            last_r     <= 1'b0;
            empty_r    <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            pair_idx_r <= pair_idx_n_s;
            ovalid_r   <= ovalid_n_s;
            act_out_r  <= act_out_n_s;
            wt_out_r   <= wt_out_n_s;
            last_r     <= last_n_s;
            empty_r    <= empty_n_s;
        end
    end

    // Block capture on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r    <= COUNT_ZERO;
            act_idx_r  <= {FIELD_W{1'b0}};
            wt_idx_r   <= {FIELD_W{1'b0}};
            act_vals_r <= {VEC_W{1'b0}};
            wt_vals_r  <= {VEC_W{1'b0}};
        end else if (accept_s) begin
            count_r    <= in_count_s;
            act_idx_r  <= in_act_idx_s;
            wt_idx_r   <= in_wt_idx_s;
            act_vals_r <= activationValues;
            wt_vals_r  <= weightValues;
        end
    end

    assign oready        = oready_s;
    assign ovalid        = ovalid_r;
    assign activationOut = act_out_r;
    assign weightOut     = wt_out_r;
    assign lastPair      = last_r;
    assign emptyBlock    = empty_r;

endmodule

// File: tb/tb_operand_pair_sequencer.sv
// Scoreboard bench for operand_pair_sequencer: stimulus pushes expected pairs
// from a lane-array model, a negedge monitor pops and compares.
module tb_operand_pair_sequencer;

    localparam int N  = 8;
    localparam int DW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            ivalid = 1'b0;
    logic            oready;
    logic [63:0]     matchResult = 64'd0;
    logic [N*DW-1:0] activationValues = '0;
    logic [N*DW-1:0] weightValues = '0;
    logic            ovalid;
    logic            iready = 1'b1;
    logic [DW-1:0]   activationOut;
    logic [DW-1:0]   weightOut;
    logic            lastPair;
    logic            emptyBlock;

    operand_pair_sequencer #(
        .BITMASK_LENGTH(8), .INDEX_BITWIDTH(3), .COUNT_BITWIDTH(4), .DATA_WIDTH(8)
    ) dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
        .matchResult(matchResult), .activationValues(activationValues),
        .weightValues(weightValues), .ovalid(ovalid), .iready(iready),
        .activationOut(activationOut), .weightOut(weightOut),
        .lastPair(lastPair), .emptyBlock(emptyBlock)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] a;
        logic [7:0] w;
        logic       last;
        int         due;
    } pair_t;

    pair_t sb[$];
    int    eq[$];
    int    total = 0;
    int    bad = 0;
    int    cycle = 0;
    int    hs_total = 0;
    int    ready_mode = 0;
    int    pidx = 0;
    logic  pat [5];

    logic [2:0] bai [N];
    logic [2:0] bwi [N];
    logic [7:0] bav [N];
    logic [7:0] bwv [N];
    logic [3:0] bcnt;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Downstream ready generator.
    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        forever begin
            @(posedge clock); #1;
            if (ready_mode == 0) iready = 1'b1;
            else if (ready_mode == 1) iready = ($urandom_range(0, 3) != 0);
            else begin
                iready = (pidx < 5) ? pat[pidx] : 1'b1;
                pidx++;
            end
        end
    end

    // Monitor state
    bit         pv = 1'b0, phs = 1'b0, prst = 1'b1, pcont = 1'b0;
    logic [7:0] ha = 8'd0, hw = 8'd0;
    logic       hl = 1'b0;
    int         start_cyc = 0;
    logic       exp_rdy;
    pair_t      e;
    int         junk;

    initial begin
        forever begin
            @(negedge clock);
            exp_rdy = !reset && (sb.size() == 0 || (sb.size() == 1 && ovalid && iready));
            chk("oready", {31'd0, oready}, {31'd0, exp_rdy});
            if (prst) begin
                chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
                chk("rst_act", {24'd0, activationOut}, 32'd0);
                chk("rst_wt", {24'd0, weightOut}, 32'd0);
                chk("rst_last", {31'd0, lastPair}, 32'd0);
                chk("rst_empty", {31'd0, emptyBlock}, 32'd0);
            end
            if (!reset && !prst) begin
                if (pv && !phs) begin
                    chk("hold_valid", {31'd0, ovalid}, 32'd1);
                    chk("hold_act", {24'd0, activationOut}, {24'd0, ha});
                    chk("hold_wt", {24'd0, weightOut}, {24'd0, hw});
                    chk("hold_last", {31'd0, lastPair}, {31'd0, hl});
                end
                if (pcont) chk("no_bubble", {31'd0, ovalid}, 32'd1);
                if (ovalid && (!pv || phs)) start_cyc = cycle;
                pcont = 1'b0;
                if (sb.size() == 0) begin
                    chk("idle_ovalid", {31'd0, ovalid}, 32'd0);
                end else if (ovalid && iready) begin
                    e = sb.pop_front();
                    chk("pair_act", {24'd0, activationOut}, {24'd0, e.a});
                    chk("pair_wt", {24'd0, weightOut}, {24'd0, e.w});
                    chk("pair_last", {31'd0, lastPair}, {31'd0, e.last});
                    if (e.due >= 0) chk("first_latency", start_cyc, e.due);
                    pcont = !e.last;
                    hs_total++;
                end
                if (eq.size() > 0 && eq[0] == cycle) begin
                    chk("empty_pulse", {31'd0, emptyBlock}, 32'd1);
                    junk = eq.pop_front();
                end else begin
                    chk("empty_quiet", {31'd0, emptyBlock}, 32'd0);
                end
            end else begin
                pcont = 1'b0;
            end
            pv   = ovalid && !reset;
            phs  = ovalid && iready && !reset;
            prst = reset;
            ha   = activationOut;
            hw   = weightOut;
            hl   = lastPair;
        end
    end

    // Present the current block; push its expected response once it is accepted.
    task automatic send_block();
        logic [63:0]     mr;
        logic [N*DW-1:0] avec, wvec;
        int              eff;
        bit              done;
        mr = {$urandom, $urandom};
        for (int k = 0; k < N; k++) begin
            mr[3*k +: 3]      = bai[k];
            mr[24 + 3*k +: 3] = bwi[k];
            avec[8*k +: 8]    = bav[k];
            wvec[8*k +: 8]    = bwv[k];
        end
        mr[51:48] = bcnt;
        @(posedge clock); #1;
        ivalid = 1'b1;
        matchResult = mr;
        activationValues = avec;
        weightValues = wvec;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clock); #1;
            if (oready) begin
                done = 1'b1;
                eff = (bcnt > 4'd8) ? 8 : int'(bcnt);
                if (eff == 0) eq.push_back(cycle + 1);
                for (int k = 0; k < eff; k++)
                    sb.push_back('{bav[bai[k]], bwv[bwi[k]], (k == eff - 1), (k == 0) ? cycle + 1 : -1});
            end
        end
        if (!done) chk("accept_timeout", {31'd0, oready}, 32'd1);
    endtask

    task automatic release_in();
        @(posedge clock); #1;
        ivalid = 1'b0;
        matchResult = {$urandom, $urandom};
        activationValues = {$urandom, $urandom};
        weightValues = {$urandom, $urandom};
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || eq.size() != 0) && t < 400) begin
            @(negedge clock); #1;
            t++;
        end
        if (sb.size() != 0) chk("drain_pairs", sb.size(), 32'd0);
        if (eq.size() != 0) chk("drain_empty", eq.size(), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic random_block();
        for (int k = 0; k < N; k++) begin
            bai[k] = 3'($urandom_range(0, 7));
            bwi[k] = 3'($urandom_range(0, 7));
            bav[k] = 8'($urandom);
            bwv[k] = 8'($urandom);
        end
        bcnt = 4'($urandom_range(0, 15));
    endtask

    task automatic directed_block(input logic [3:0] cnt);
        for (int k = 0; k < N; k++) begin
            bai[k] = 3'd0;
            bwi[k] = 3'd0;
            bav[k] = 8'(8'h10 + k);
            bwv[k] = 8'(8'h20 + k);
        end
        bai[0] = 3'd0; bai[1] = 3'd2; bai[2] = 3'd5;
        bwi[0] = 3'd1; bwi[1] = 3'd1; bwi[2] = 3'd3;
        bcnt = cnt;
    endtask

    initial begin
        int base;
        int t;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // single block, always ready
        directed_block(4'd3);
        send_block(); release_in(); drain();

        // same block with ready pattern 1,0,0,1,1
        send_block();
        pidx = 0; ready_mode = 2;
        release_in(); drain();
        ready_mode = 0;

        // back-to-back: count 2 then count 1
        directed_block(4'd2);
        send_block();
        directed_block(4'd1);
        send_block();
        release_in(); drain();

        // zero count, then overflowed count field
        directed_block(4'd0);
        send_block(); release_in(); drain();
        random_block(); bcnt = 4'd15;
        send_block(); release_in(); drain();

        // reset after three handshakes of an eight-pair block
        random_block(); bcnt = 4'd8;
        base = hs_total;
        send_block(); release_in();
        t = 0;
        while (hs_total < base + 3 && t < 100) begin
            @(negedge clock); #1;
            t++;
        end
        if (hs_total < base + 3) chk("reset_wait", hs_total - base, 32'd3);
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        eq.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        directed_block(4'd3);
        send_block(); release_in(); drain();

        // randomized blocks with random backpressure and gaps
        ready_mode = 1;
        for (int b = 0; b < 60; b++) begin
            random_block();
            send_block();
            if ($urandom_range(0, 1) == 1) release_in();
        end
        release_in();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: cycle=%0d limit=50000", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/operand_pair_sequencer.md
Name: operand_pair_sequencer

Overview:
- Downstream of the 8-lane operand matcher.
- Takes one registered 64-bit match result per block: 24-bit packed activation indices, 24-bit packed weight indices and a 4-bit pair count. Also takes the block's compressed activation and weight value vectors.
- Streams the matched (activation, weight) value pairs one per cycle to the MAC lane, using valid/ready handshakes on both sides.

Parameters:
- BITMASK_LENGTH, 8, lanes per block; also the maximum number of pairs.
- INDEX_BITWIDTH, 3, width of each packed index.
- COUNT_BITWIDTH, 4, width of the pair-count field.
- DATA_WIDTH, 8, width of each activation and weight value.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  synchronous, active-high reset.
- ivalid  in  1  upstream block valid.
- oready  out  1  block ready to accept a new match result.
- matchResult  in  64  [23:0] activation indices (index k at [3k+2:3k]); [47:24] weight indices; [51:48] pair count; [63:52] ignored.
- activationValues  in  BITMASK_LENGTH*DATA_WIDTH  compressed activations; value j at [(j+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- weightValues  in  BITMASK_LENGTH*DATA_WIDTH  compressed weights, same packing.
- ovalid  out  1  output pair valid.
- iready  in  1  downstream MAC ready.
- activationOut  out  DATA_WIDTH  activation value of the current pair.
- weightOut  out  DATA_WIDTH  weight value of the current pair.
- lastPair  out  1  marks the final pair of a block; qualified by ovalid.
- emptyBlock  out  1  one-cycle pulse when a block with zero pairs was consumed.

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, reset.
- Input acceptance: a block is accepted on a cycle with ivalid && oready. On acceptance, matchResult, both value vectors and the clamped count are captured into internal registers.
- oready = (state==IDLE) || (state==EMIT && ovalid && iready && lastPair). Back-to-back blocks therefore have zero bubbles.
- Count clamp: effective count = min(count field, BITMASK_LENGTH). Field values 9..15 are treated as 8.
- States:
  - IDLE, 0 pairs pending.
  - EMIT, pairIdx in 0..count-1.
- IDLE transitions:
  - Accept with count>0 -> EMIT, pairIdx=0.
  - Accept with count==0 -> stay IDLE, emptyBlock=1 in the next cycle.
- EMIT, on an output handshake (ovalid && iready):
  - If not last: pairIdx increments and the next pair is presented the following cycle.
  - If last and a new block is accepted in the same cycle: reload pairIdx=0 and present the first pair of the new block next cycle. If that block has count 0, go to IDLE and pulse emptyBlock.
  - If last and no new block: go to IDLE and drop ovalid next cycle.
- Pair mapping: for pair k, activationOut = activationValues[aIdx_k], where aIdx_k = captured activation index field k. weightOut = weightValues[wIdx_k], looked up the same way from the weight index field.
- lastPair = (pairIdx == count-1).
- Latency: first pair is visible with ovalid=1 one cycle after acceptance. All outputs are registered.
- Backpressure: while ovalid && !iready, ovalid, activationOut, weightOut and lastPair are held stable and pairIdx does not advance.
- ovalid never drops without a handshake.
- Upstream signals are ignored when not accepted.
- Reset values: ovalid=0, activationOut=0, weightOut=0, lastPair=0, emptyBlock=0, state=IDLE, pairIdx=0.
- oready=0 in any cycle where reset=1, and is 1 in the first cycle after reset is deasserted.
- Reset mid-block: remaining pairs are discarded with no partial output afterwards.
- Pipelining: no combinational path from ivalid or iready to ovalid or the data outputs. oready depends combinationally on iready, which is allowed.

Test Plan:
- Single block: count=3, activation indices {0,2,5}, weight indices {1,1,3}, activationValues[j]=0x10+j, weightValues[j]=0x20+j, iready=1.
  -> Pairs (0x10,0x21), (0x12,0x21), (0x15,0x23) on 3 consecutive cycles starting 1 cycle after accept; lastPair on the third only.
- Backpressure: same block, iready toggles 1,0,0,1,1.
  -> Each pair held stable while iready=0; 3 handshakes total; oready=0 until the last handshake.
- Back-to-back: two blocks, count=2 then count=1, ivalid held high, iready=1.
  -> 3 output pairs on 3 consecutive cycles; second block accepted in the same cycle as the first block's last handshake.
- Zero-count and overflow:
  - count=0 -> no ovalid; emptyBlock=1 for exactly one cycle.
  - count field=15 with 8 index pairs -> exactly 8 pairs emitted, lastPair on the 8th.
- Reset mid-block: count=8, assert reset after 3 handshakes.
  -> Next cycle ovalid=0 and outputs 0; oready=1 after reset deasserts; the next block starts from its own pair 0.
